// File: rtl/pll_seq_pkg.sv
// Shared state encoding and sizing helper for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_ASSERT_RST = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_RUN        = 3'd4,
        ST_FAIL       = 3'd5
    } pll_state_e;

    // The shared timer is loaded with (duration - 1), so it needs clog2 of the longest duration.
    function automatic int timer_width(input int rst_cycles, input int lock_timeout,
                                       input int settle_cycles);
        int max_v;
        max_v = rst_cycles;
        max_v = (lock_timeout > max_v) ? lock_timeout : max_v;
        max_v = (settle_cycles > max_v) ? settle_cycles : max_v;
        return (max_v > 1) ? $clog2(max_v) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs; reset value is a parameter.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences PLLE2 reset/power-down, qualifies LOCKED, and raises READY once lock is stable.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             ENABLE,
    input  logic                             RESTART,
    input  logic                             PLL_LOCKED,
    output logic                             PLL_RST,
    output logic                             PLL_PWRDWN,
    output logic                             READY,
    output logic                             FAIL,
    output logic [2:0]                       STATE,
    output logic [$clog2(MAX_RETRIES+1)-1:0] RETRY_COUNT,
    output logic [CNT_W-1:0]                 LOSS_COUNT
);

    localparam int TW = timer_width(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [TW-1:0]    RST_LOAD    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]    LOCK_LOAD   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_LIMIT = RW'(MAX_RETRIES);
    localparam logic [CNT_W-1:0] LOSS_MAX    = {CNT_W{1'b1}};

    pll_state_e       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d, load_s;
    logic [RW-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             pll_rst_q, pll_rst_d;
    logic             pwrdwn_q, pwrdwn_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             lock_s;
    logic             enter_s;
    logic             timer_done_s;

    sync_2ff #(.RESET_VAL(1'b0)) u_lock_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .d     (PLL_LOCKED),
        .q     (lock_s)
    );

    assign timer_done_s = (timer_q == {TW{1'b0}});

    // Next-state and counter update; ENABLE beats RESTART beats per-state rules.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        enter_s = 1'b0;
        if (!ENABLE) begin
            state_d = ST_OFF;
            retry_d = {RW{1'b0}};
            enter_s = 1'b1;
        end else if (RESTART && (state_q != ST_OFF)) begin
            state_d = ST_ASSERT_RST;
            retry_d = {RW{1'b0}};
            enter_s = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_ASSERT_RST;
                    enter_s = 1'b1;
                end
                ST_ASSERT_RST: begin
                    if (timer_done_s) begin
                        state_d = ST_WAIT_LOCK;
                        enter_s = 1'b1;
                    end else begin
                        state_d = ST_ASSERT_RST;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_SETTLE;
                        enter_s = 1'b1;
                    end else if (timer_done_s) begin
                        retry_d = retry_q + RW'(1'b1);
                        state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_ASSERT_RST;
                        enter_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_SETTLE: begin
                    // A lock glitch here restarts the wait without spending a retry.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        enter_s = 1'b1;
                    end else if (timer_done_s) begin
                        state_d = ST_RUN;
                        retry_d = {RW{1'b0}};
                        enter_s = 1'b1;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_ASSERT_RST;
                        loss_d  = (loss_q == LOSS_MAX) ? loss_q : loss_q + CNT_W'(1'b1);
                        enter_s = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_OFF;
                    enter_s = 1'b1;
                end
            endcase
        end
    end

    // Timer reload value for the state being entered.
    always_comb begin
        load_s = {TW{1'b0}};
        case (state_d)
            ST_ASSERT_RST: load_s = RST_LOAD;
            ST_WAIT_LOCK:  load_s = LOCK_LOAD;
            ST_SETTLE:     load_s = SETTLE_LOAD;
            default:       load_s = {TW{1'b0}};
        endcase
        if (enter_s) begin
            timer_d = load_s;
        end else if (!timer_done_s) begin
            timer_d = timer_q - TW'(1'b1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Pin and status values are decoded from the next state so they register in step with it.
    always_comb begin
        pll_rst_d = 1'b1;
        pwrdwn_d  = 1'b0;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
        case (state_d)
            ST_OFF:        pwrdwn_d  = 1'b1;
            ST_ASSERT_RST: pll_rst_d = 1'b1;
            ST_WAIT_LOCK:  pll_rst_d = 1'b0;
            ST_SETTLE:     pll_rst_d = 1'b0;
            ST_RUN: begin
                pll_rst_d = 1'b0;
                ready_d   = 1'b1;
            end
            ST_FAIL:       fail_d    = 1'b1;
            default:       pwrdwn_d  = 1'b1;
        endcase
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_OFF;
            timer_q   <= {TW{1'b0}};
            retry_q   <= {RW{1'b0}};
            loss_q    <= {CNT_W{1'b0}};
            pll_rst_q <= 1'b1;
            pwrdwn_q  <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            pwrdwn_q  <= pwrdwn_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    assign STATE       = state_q;
    assign RETRY_COUNT = retry_q;
    assign LOSS_COUNT  = loss_q;
    assign PLL_RST     = pll_rst_q;
    assign PLL_PWRDWN  = pwrdwn_q;
    assign READY       = ready_q;
    assign FAIL        = fail_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench: directed scenarios plus random stimulus against a cycle-count reference model.
module tb_pll_lock_sequencer;

    localparam int RST_C  = 4;
    localparam int LT     = 20;
    localparam int SET_C  = 8;
    localparam int MAXR   = 2;
    localparam int CNTW   = 2;
    localparam int LOSS_SAT = (1 << CNTW) - 1;

    localparam int S_OFF = 0, S_RST = 1, S_WAIT = 2, S_SETTLE = 3, S_RUN = 4, S_FAIL = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       restart = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst, pll_pwrdwn, ready, fail;
    logic [2:0] state;
    logic [1:0] retry_count;
    logic [1:0] loss_count;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    pll_lock_sequencer #(
        .RST_CYCLES    (RST_C),
        .LOCK_TIMEOUT  (LT),
        .SETTLE_CYCLES (SET_C),
        .MAX_RETRIES   (MAXR),
        .CNT_W         (CNTW)
    ) dut (
        .CLK         (clk),
        .RESET_N     (rst_n),
        .ENABLE      (enable),
        .RESTART     (restart),
        .PLL_LOCKED  (pll_locked),
        .PLL_RST     (pll_rst),
        .PLL_PWRDWN  (pll_pwrdwn),
        .READY       (ready),
        .FAIL        (fail),
        .STATE       (state),
        .RETRY_COUNT (retry_count),
        .LOSS_COUNT  (loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state plus cycles spent in it, and the last two LOCKED samples.
    int m_state = S_OFF, m_elapsed = 0, m_retry = 0, m_loss = 0, m_nxt = 0;
    bit m_p1 = 1'b0, m_p2 = 1'b0, m_ls = 1'b0, m_entered = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state = S_OFF; m_elapsed = 0; m_retry = 0; m_loss = 0;
                m_p1 = 1'b0; m_p2 = 1'b0;
            end else begin
                m_ls = m_p2; m_p2 = m_p1; m_p1 = pll_locked;
                m_nxt = m_state;
                m_entered = 1'b0;
                if (!enable) begin
                    m_nxt = S_OFF; m_retry = 0;
                end else if (restart && m_state != S_OFF) begin
                    m_nxt = S_RST; m_retry = 0; m_entered = 1'b1;
                end else begin
                    case (m_state)
                        S_OFF:  m_nxt = S_RST;
                        S_RST:  if (m_elapsed + 1 >= RST_C) m_nxt = S_WAIT;
                        S_WAIT: begin
                            if (m_ls) m_nxt = S_SETTLE;
                            else if (m_elapsed + 1 >= LT) begin
                                m_retry++;
                                m_nxt = (m_retry == MAXR) ? S_FAIL : S_RST;
                            end
                        end
                        S_SETTLE: begin
                            if (!m_ls) m_nxt = S_WAIT;
                            else if (m_elapsed + 1 >= SET_C) begin m_nxt = S_RUN; m_retry = 0; end
                        end
                        S_RUN: if (!m_ls) begin
                            m_nxt = S_RST;
                            if (m_loss < LOSS_SAT) m_loss++;
                        end
                        default: m_nxt = m_state;
                    endcase
                end
                if (m_nxt != m_state) m_entered = 1'b1;
                m_elapsed = m_entered ? 0 : m_elapsed + 1;
                m_state = m_nxt;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("state", int'(state), m_state);
            check("pll_rst", int'(pll_rst),
                  (m_state == S_OFF || m_state == S_RST || m_state == S_FAIL) ? 1 : 0);
            check("pll_pwrdwn", int'(pll_pwrdwn), (m_state == S_OFF) ? 1 : 0);
            check("ready", int'(ready), (m_state == S_RUN) ? 1 : 0);
            check("fail", int'(fail), (m_state == S_FAIL) ? 1 : 0);
            check("retry_count", int'(retry_count), m_retry);
            check("loss_count", int'(loss_count), m_loss);
            check("ready_with_rst", int'(ready & pll_rst), 0);
        end
    end

    // kind 0 waits on STATE, kind 1 on READY; n counts negedges consumed.
    task automatic wait_for(input int kind, input int val, input int budget,
                            input string name, output int n);
        bit hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            hit = (kind == 0) ? (int'(state) == val) : (int'(ready) == val);
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s: value never reached %0d within %0d cycles", name, val, budget);
        end
    endtask

    int n, cnt, mode;
    bit saw_wait;

    initial begin
        rst_n = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_pll_rst", int'(pll_rst), 1);
        check("rst_pwrdwn", int'(pll_pwrdwn), 1);
        check("rst_ready", int'(ready), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_retry", int'(retry_count), 0);
        check("rst_loss", int'(loss_count), 0);
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;

        // 1. Normal bring-up
        wait_for(0, S_RST, 5, "enter_assert", n);
        check("t1_pwrdwn", int'(pll_pwrdwn), 0);
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pll_rst) cnt++;
            else break;
        end
        check("t1_rst_width", cnt, 4);
        repeat (9) @(negedge clk);
        pll_locked = 1'b1;
        wait_for(1, 1, 40, "t1_ready", n);
        check("t1_ready_latency", n, 11);
        check("t1_retry", int'(retry_count), 0);

        // 2. Lock timeout to FAIL, then RESTART
        restart = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        wait_for(0, S_FAIL, 100, "t2_fail", n);
        check("t2_fail_latency", n + 1, 49);
        check("t2_fail", int'(fail), 1);
        check("t2_retry", int'(retry_count), 2);
        repeat (5) @(negedge clk);
        check("t2_hold_rst", int'(pll_rst), 1);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t2_restart_fail", int'(fail), 0);
        check("t2_restart_retry", int'(retry_count), 0);
        cnt = (pll_rst && int'(state) == S_RST) ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pll_rst) cnt++;
            else break;
        end
        check("t2_rst_width", cnt, 4);
        pll_locked = 1'b1;
        wait_for(1, 1, 60, "t2_ready", n);

        // 3. One-cycle lock loss in RUN
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        wait_for(1, 0, 10, "t3_drop", n);
        check("t3_ready_drop", n + 1, 3);
        check("t3_loss", int'(loss_count), 1);
        wait_for(1, 1, 60, "t3_reready", n);

        // 4. Glitch during SETTLE
        pll_locked = 1'b0;
        wait_for(0, S_WAIT, 20, "t4_wait", n);
        pll_locked = 1'b1;
        wait_for(0, S_SETTLE, 20, "t4_settle", n);
        repeat (4) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        cnt = 1;
        saw_wait = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cnt++;
            if (int'(state) == S_WAIT) saw_wait = 1'b1;
            if (ready) break;
        end
        check("t4_saw_wait", int'(saw_wait), 1);
        check("t4_ready_latency", cnt, 12);
        check("t4_retry", int'(retry_count), 0);

        // 5. Control priority
        pll_locked = 1'b0;
        wait_for(0, S_WAIT, 20, "t5_wait", n);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("t5_off_state", int'(state), S_OFF);
        check("t5_off_pwrdwn", int'(pll_pwrdwn), 1);
        check("t5_off_rst", int'(pll_rst), 1);
        enable = 1'b1;
        wait_for(0, S_WAIT, 20, "t5_wait2", n);
        enable = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t5_both_state", int'(state), S_OFF);

        // 6. LOSS_COUNT saturation and retention
        enable = 1'b1;
        pll_locked = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_for(1, 1, 80, "t6_ready", n);
            pll_locked = 1'b0;
            @(negedge clk);
            pll_locked = 1'b1;
            wait_for(1, 0, 10, "t6_drop", n);
        end
        check("t6_loss_sat", int'(loss_count), 3);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        check("t6_loss_kept", int'(loss_count), 3);
        wait_for(1, 1, 80, "t6_ready_final", n);

        // Asynchronous reset in RUN, away from any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_ready", int'(ready), 0);
        check("t5_async_rst", int'(pll_rst), 1);
        check("t6_loss_clear", int'(loss_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random phase
        mode = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) mode = int'($urandom_range(0, 2));
            @(negedge clk);
            restart = ($urandom_range(0, 99) < 1);
            enable = ($urandom_range(0, 199) != 0);
            case (mode)
                0:       pll_locked = 1'b0;
                1:       pll_locked = ($urandom_range(0, 199) < 2) ? 1'b0 : 1'b1;
                default: pll_locked = 1'($urandom_range(0, 1));
            endcase
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
